// File: rtl/layer1_counter_func0.sv
// Layer-1 MAC completion counter plus hard-sigmoid activation.
// Counts MAC acknowledge pulses up to N_INPUTS and raises a sticky done flag;
// the activation path is independent, purely combinational logic.
module layer1_counter_func0 #(
  parameter int unsigned N_INPUTS  = 2,
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack,
  output logic              ack__mac,
  input  logic signed [7:0] z__value,
  output logic signed [7:0] a
);

  // Wide enough to hold N_INPUTS itself; never narrower than one bit.
  localparam int unsigned CntW = (N_INPUTS < 1) ? 1 : $clog2(N_INPUTS + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(N_INPUTS);

  // 1.0 and 0.5 in the Q-format, as 10-bit signed constants.
  localparam logic signed [9:0] One  = 10'sd1 <<< FRAC_BITS;
  localparam logic signed [9:0] Half = 10'sd1 <<< (FRAC_BITS - 1);

  logic [CntW-1:0] count_q, count_d;
  logic            done_q, done_d;

  // Next-state: count accepted pulses, saturate once done.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (ack && !done_q) begin
      count_d = count_q + CntW'(1);
      if (count_d == CntDone) begin
        done_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign ack__mac = done_q;

  logic signed [9:0] z_ext;
  logic signed [9:0] z_quarter;
  logic signed [9:0] sum;

  // Hard sigmoid: clamp(z/4 + 0.5, 0, 1.0); >>> floors toward -inf.
  always_comb begin
    z_ext     = {{2{z__value[7]}}, z__value};
    z_quarter = z_ext >>> 2;
    sum       = z_quarter + Half;
    if (sum < 10'sd0) begin
      a = 8'sd0;
    end else if (sum > One) begin
      a = One[7:0];
    end else begin
      a = sum[7:0];
    end
  end

endmodule

// File: tb/tb_layer1_counter_func0.sv
// Self-checking bench for layer1_counter_func0: counter scenarios via a
// scoreboard of expected done flags, plus activation sweep and exhaustive check.
module tb_layer1_counter_func0;

  localparam int unsigned NIn = 2;

  logic              clk;
  logic              rst;
  logic              ack;
  logic              ack__mac;
  logic signed [7:0] z__value;
  logic signed [7:0] a;

  int checks = 0;
  int errors = 0;

  // Bench-side reference state for the counter.
  int   mdl_cnt = 0;
  logic mdl_done = 1'b0;

  logic              exp_mac_q[$];
  logic signed [7:0] exp_a_q[$];

  layer1_counter_func0 #(
    .N_INPUTS (NIn),
    .FRAC_BITS(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack),
    .ack__mac(ack__mac),
    .z__value(z__value),
    .a       (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive ack for one cycle, predict the flag after the edge, sample #1 later.
  task automatic step(input logic ack_v);
    ack = ack_v;
    if (!rst) begin
      mdl_cnt  = 0;
      mdl_done = 1'b0;
    end else if (ack_v && !mdl_done) begin
      mdl_cnt++;
      if (mdl_cnt == NIn) mdl_done = 1'b1;
    end
    exp_mac_q.push_back(mdl_done);
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic model_reset();
    mdl_cnt  = 0;
    mdl_done = 1'b0;
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ack__mac !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ack__mac=%b expected 0", ack__mac);
    end
    for (int i = 0; i < 4; i++) begin
      step(i[0] ? 1'b0 : 1'b1);
      exp = exp_mac_q.pop_front();
      checks++;
      if (ack__mac !== exp) begin
        errors++;
        $display("FAIL reset_ack_ignored[%0d]: ack__mac=%b expected %b", i, ack__mac, exp);
      end
    end
    rst = 1'b1;
    step(1'b0);
    exp = exp_mac_q.pop_front();
    checks++;
    if (ack__mac !== exp) begin
      errors++;
      $display("FAIL reset_release: ack__mac=%b expected %b", ack__mac, exp);
    end
  endtask

  task automatic test_completion();
    logic exp;
    logic pattern[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(pattern[i]);
      exp = exp_mac_q.pop_front();
      checks++;
      if (ack__mac !== exp) begin
        errors++;
        $display("FAIL completion[%0d]: ack__mac=%b expected %b", i, ack__mac, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic exp;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      exp = exp_mac_q.pop_front();
      checks++;
      if (ack__mac !== exp) begin
        errors++;
        $display("FAIL saturation[%0d]: ack__mac=%b expected %b", i, ack__mac, exp);
      end
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ack__mac !== 1'b0) begin
      errors++;
      $display("FAIL saturation_async_clear: ack__mac=%b expected 0", ack__mac);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_count();
    logic exp;
    step(1'b1);
    exp = exp_mac_q.pop_front();
    checks++;
    if (ack__mac !== exp) begin
      errors++;
      $display("FAIL midcount_first: ack__mac=%b expected %b", ack__mac, exp);
    end
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      exp = exp_mac_q.pop_front();
      checks++;
      if (ack__mac !== exp) begin
        errors++;
        $display("FAIL midcount_restart[%0d]: ack__mac=%b expected %b", i, ack__mac, exp);
      end
    end
  endtask

  task automatic test_act_sweep();
    logic signed [7:0] zs[7] = '{8'sd0, 8'sd5, -8'sd5, 8'sd32, -8'sd32, 8'sd127, -8'sd128};
    logic signed [7:0] as[7] = '{8'sd8, 8'sd9, 8'sd6, 8'sd16, 8'sd0, 8'sd16, 8'sd0};
    logic signed [7:0] exp;
    for (int i = 0; i < 7; i++) begin
      z__value = zs[i];
      exp_a_q.push_back(as[i]);
      #1;
      exp = exp_a_q.pop_front();
      checks++;
      if (a !== exp) begin
        errors++;
        $display("FAIL act_sweep z=%0d: a=%0d expected %0d", zs[i], a, exp);
      end
    end
  endtask

  // Reference: floor(z/4) via integer arithmetic, then +8 and clamp to [0,16].
  task automatic test_act_exhaustive();
    int z, fl, r;
    logic signed [7:0] exp;
    for (int i = -128; i < 128; i++) begin
      z  = i;
      fl = (z - (((z % 4) + 4) % 4)) / 4;
      r  = fl + 8;
      if (r < 0) r = 0;
      if (r > 16) r = 16;
      z__value = 8'(i);
      exp_a_q.push_back(8'(r));
      #1;
      exp = exp_a_q.pop_front();
      checks++;
      if (a !== exp || $signed(a) < 0 || $signed(a) > 16) begin
        errors++;
        $display("FAIL act_exhaustive z=%0d: a=%0d expected %0d", i, a, exp);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    ack      = 1'b0;
    z__value = 8'sd0;
    @(posedge clk);
    #1;
    test_reset();
    test_completion();
    test_saturation();
    test_reset_mid_count();
    test_act_sweep();
    test_act_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
